// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS tuning-word sweep generator.
// Holds the sweep state encoding, the mode codes and the default widths.
package dds_sweep_pkg;

  localparam int unsigned ACC_W_DEF   = 32;
  localparam int unsigned DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

// File: rtl/sweep_dwell_counter.sv
// Loadable down-counter that sets how long each tuning word is held.
// A load takes priority over a decrement; zero_o flags an expired dwell.
module sweep_dwell_counter
  import dds_sweep_pkg::*;
#(
  parameter int unsigned g_dwellWidth = DWELL_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [g_dwellWidth-1:0] val_i,
  output logic                    zero_o
);

  logic [g_dwellWidth-1:0] cnt_q;
  logic [g_dwellWidth-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_ftw_sweep_generator.sv
// Linear FTW sweep feeding the DDS phase accumulator input.
// Single, sawtooth and triangle sweeps with endpoint clamping.
module dds_ftw_sweep_generator
  import dds_sweep_pkg::*;
#(
  parameter int unsigned g_accWidth   = ACC_W_DEF,
  parameter int unsigned g_dwellWidth = DWELL_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic                    io_abort,
  input  logic [g_accWidth-1:0]   io_startFtw,
  input  logic [g_accWidth-1:0]   io_stopFtw,
  input  logic [g_accWidth-1:0]   io_stepFtw,
  input  logic [g_dwellWidth-1:0] io_dwell,
  input  logic [1:0]              io_mode,
  output logic [g_accWidth-1:0]   io_ftw,
  output logic                    io_busy,
  output logic                    io_done
);

  typedef logic [g_accWidth-1:0] ftw_t;

  state_e                  state_q, state_d;
  ftw_t                    ftw_q, ftw_d;
  ftw_t                    lo_q, lo_d;
  ftw_t                    hi_q, hi_d;
  ftw_t                    step_q, step_d;
  logic [g_dwellWidth-1:0] dwell_q, dwell_d;
  logic [1:0]              mode_q, mode_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cnt_load, cnt_en, cnt_zero;
  logic [g_dwellWidth-1:0] cnt_val;

  // Carry-out of the wide sum counts as overshoot and clamps to hi.
  function automatic ftw_t up_val(input ftw_t f, input ftw_t s,
                                  input ftw_t hi);
    logic [g_accWidth:0] sum;
    sum = {1'b0, f} + {1'b0, s};
    if (sum >= {1'b0, hi}) return hi;
    return sum[g_accWidth-1:0];
  endfunction

  function automatic ftw_t dn_val(input ftw_t f, input ftw_t s,
                                  input ftw_t lo);
    logic [g_accWidth:0] diff;
    diff = {1'b0, f} - {1'b0, s};
    if (diff[g_accWidth] || (diff[g_accWidth-1:0] <= lo)) return lo;
    return diff[g_accWidth-1:0];
  endfunction

  assign cnt_val = (state_q == ST_IDLE) ? io_dwell : dwell_q;

  sweep_dwell_counter #(
    .g_dwellWidth(g_dwellWidth)
  ) u_dwell (
    .clock (clock),
    .reset (reset),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .val_i (cnt_val),
    .zero_o(cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    ftw_d    = ftw_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (io_abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (io_start) begin
            lo_d    = io_startFtw;
            hi_d    = io_stopFtw;
            step_d  = io_stepFtw;
            dwell_d = io_dwell;
            mode_d  = io_mode;
            ftw_d   = io_startFtw;
            if ((io_stepFtw == '0) || (io_stopFtw <= io_startFtw)) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_UP;
              busy_d   = 1'b1;
              cnt_load = 1'b1;
            end
          end
        end
        ST_UP: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            cnt_load = 1'b1;
            if (ftw_q == hi_q) begin
              unique case (1'b1)
                (mode_q == MODE_SAW): ftw_d = lo_q;
                (mode_q == MODE_TRI): begin
                  state_d = ST_DOWN;
                  ftw_d   = dn_val(ftw_q, step_q, lo_q);
                end
                default: begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              endcase
            end else begin
              ftw_d = up_val(ftw_q, step_q, hi_q);
            end
          end
        end
        ST_DOWN: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            cnt_load = 1'b1;
            if (ftw_q == lo_q) begin
              state_d = ST_UP;
              ftw_d   = up_val(ftw_q, step_q, hi_q);
            end else begin
              ftw_d = dn_val(ftw_q, step_q, lo_q);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ftw_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_SINGLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io_ftw  = ftw_q;
  assign io_busy = busy_q;
  assign io_done = done_q;

endmodule
